// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the shared 16x8 instruction/data memory.
// Optional lock/burst hold is built when MEM_ARB_LOCK_EN is defined.
module mem_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_lock,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_last;
  logic   w_nextLast;
  logic   w_hold0;
  logic   w_hold1;

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST);

  logic [CNT_W-1:0] r_burstCnt;
  logic [CNT_W-1:0] w_nextBurstCnt;

  // A locked owner keeps the grant until it has had MAX_BURST cycles in a row.
  always_comb begin
    w_hold0        = (r_state == G0) && m0_req && m0_lock && (r_burstCnt < CNT_W'(MAX_BURST - 1));
    w_hold1        = (r_state == G1) && m1_req && m1_lock && (r_burstCnt < CNT_W'(MAX_BURST - 1));
    w_nextBurstCnt = (w_hold0 || w_hold1) ? r_burstCnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_burstCnt <= '0;
    end else begin
      r_burstCnt <= w_nextBurstCnt;
    end
  end
`else
  logic w_unusedLock;

  assign w_unusedLock = ^{m0_lock, m1_lock, (MAX_BURST > 0)};
  assign w_hold0      = 1'b0;
  assign w_hold1      = 1'b0;
`endif

  always_comb begin
    w_nextState = IDLE;
    w_nextLast  = r_last;
    if (w_hold0) begin
      w_nextState = G0;
    end else if (w_hold1) begin
      w_nextState = G1;
    end else if (m0_req && m1_req) begin
      w_nextState = r_last ? G0 : G1;
    end else if (m0_req) begin
      w_nextState = G0;
    end else if (m1_req) begin
      w_nextState = G1;
    end
    if (w_nextState == G0) begin
      w_nextLast = 1'b0;
    end else if (w_nextState == G1) begin
      w_nextLast = 1'b1;
    end
  end

  // last resets to 1 so that master 0 wins the very first tie.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
    end
  end

  assign m0_gnt = (r_state == G0);
  assign m1_gnt = (r_state == G1);

  // A granted master that has dropped req wastes the slot: no strobes at all.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      G0: begin
        if (m0_req) begin
          mem_addr  = m0_addr;
          mem_wdata = m0_wdata;
          mem_write = m0_write;
          mem_read  = !m0_write;
        end
      end
      G1: begin
        if (m1_req) begin
          mem_addr  = m1_addr;
          mem_wdata = m1_wdata;
          mem_write = m1_write;
          mem_read  = !m1_write;
        end
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if ((r_state == G0) && m0_req && !m0_write) begin
        m0_rdata  <= mem_rdata;
        m0_rvalid <= 1'b1;
      end
      if ((r_state == G1) && m1_req && !m1_write) begin
        m1_rdata  <= mem_rdata;
        m1_rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a behavioural 16x8 memory.
// Lock expectations follow MEM_ARB_LOCK_EN as seen by this compile.
module tb_mem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic       r0, w0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       g0, g1, mr, mw;
    logic [3:0] ma;
    logic [7:0] md;
    logic       v0, v1;
    logic [7:0] rd0, rd1;
  } vec_t;

  logic       clk;
  logic       clr;
  logic       m0_req, m1_req, m0_write, m1_write, m0_lock, m1_lock;
  logic [3:0] m0_addr, m1_addr, mem_addr;
  logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write;

  logic       tbLoad;
  logic [7:0] tbMem [16];
  int         checks;
  int         errors;
  vec_t       vecs [19];
  logic [7:0] expG0;
  logic [7:0] expG1;

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .clr(clr),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_write(m0_write), .m1_write(m1_write),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read, write on the rising edge, preload while tbLoad is high.
  assign mem_rdata = tbMem[mem_addr];
  always @(posedge clk) begin
    if (tbLoad) begin
      for (int i = 0; i < 16; i++) tbMem[i] <= 8'(i);
      tbMem[2] <= 8'h54;
      tbMem[3] <= 8'h11;
      tbMem[5] <= 8'hA5;
      tbMem[7] <= 8'h1C;
    end else if (mem_write) begin
      tbMem[mem_addr] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_req   = v.r0;
    m0_write = v.w0;
    m0_addr  = v.a0;
    m0_wdata = v.d0;
    m1_req   = v.r1;
    m1_write = v.w1;
    m1_addr  = v.a1;
    m1_wdata = v.d1;
    #1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("row%0d m0_gnt", idx), 8'(m0_gnt), 8'(v.g0));
    checkOutput($sformatf("row%0d m1_gnt", idx), 8'(m1_gnt), 8'(v.g1));
    checkOutput($sformatf("row%0d mem_read", idx), 8'(mem_read), 8'(v.mr));
    checkOutput($sformatf("row%0d mem_write", idx), 8'(mem_write), 8'(v.mw));
    checkOutput($sformatf("row%0d mem_addr", idx), 8'(mem_addr), 8'(v.ma));
    checkOutput($sformatf("row%0d mem_wdata", idx), mem_wdata, v.md);
    checkOutput($sformatf("row%0d m0_rvalid", idx), 8'(m0_rvalid), 8'(v.v0));
    checkOutput($sformatf("row%0d m1_rvalid", idx), 8'(m1_rvalid), 8'(v.v1));
    checkOutput($sformatf("row%0d m0_rdata", idx), m0_rdata, v.rd0);
    checkOutput($sformatf("row%0d m1_rdata", idx), m1_rdata, v.rd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Each row is one cycle: inputs driven for it, outputs expected during it.
    vecs[0]  = '{H,L,4'h2,8'h99, H,L,4'h5,8'h66, L,L,L,L,4'h0,8'h00, L,L,8'h00,8'h00};
    vecs[1]  = '{H,L,4'h2,8'h99, H,L,4'h5,8'h66, H,L,H,L,4'h2,8'h99, L,L,8'h00,8'h00};
    vecs[2]  = '{L,L,4'h2,8'h99, H,L,4'h5,8'h66, L,H,H,L,4'h5,8'h66, H,L,8'h54,8'h00};
    vecs[3]  = '{L,L,4'h2,8'h99, L,L,4'h5,8'h66, L,H,L,L,4'h0,8'h00, L,H,8'h54,8'hA5};
    vecs[4]  = '{H,L,4'h3,8'h99, H,H,4'h3,8'h55, L,L,L,L,4'h0,8'h00, L,L,8'h54,8'hA5};
    vecs[5]  = '{H,L,4'h3,8'h99, H,H,4'h3,8'h55, H,L,H,L,4'h3,8'h99, L,L,8'h54,8'hA5};
    vecs[6]  = '{H,L,4'h3,8'h99, H,H,4'h3,8'h55, L,H,L,H,4'h3,8'h55, H,L,8'h11,8'hA5};
    vecs[7]  = '{H,L,4'h3,8'h99, L,L,4'h3,8'h55, H,L,H,L,4'h3,8'h99, L,L,8'h11,8'hA5};
    vecs[8]  = '{L,L,4'h3,8'h99, L,L,4'h3,8'h55, H,L,L,L,4'h0,8'h00, H,L,8'h55,8'hA5};
    vecs[9]  = '{H,L,4'h7,8'h99, L,L,4'h0,8'h00, L,L,L,L,4'h0,8'h00, L,L,8'h55,8'hA5};
    vecs[10] = '{H,L,4'h7,8'h99, L,L,4'h0,8'h00, H,L,H,L,4'h7,8'h99, L,L,8'h55,8'hA5};
    vecs[11] = '{L,L,4'h7,8'h99, L,L,4'h0,8'h00, H,L,L,L,4'h0,8'h00, H,L,8'h1C,8'hA5};
    vecs[12] = '{L,L,4'h7,8'h99, H,H,4'h3,8'hEE, L,L,L,L,4'h0,8'h00, L,L,8'h1C,8'hA5};
    vecs[13] = '{L,L,4'h7,8'h99, L,H,4'h3,8'hEE, L,H,L,L,4'h0,8'h00, L,L,8'h1C,8'hA5};
    vecs[14] = '{H,L,4'h3,8'h99, L,L,4'h0,8'h00, L,L,L,L,4'h0,8'h00, L,L,8'h1C,8'hA5};
    vecs[15] = '{H,L,4'h3,8'h99, L,L,4'h0,8'h00, H,L,H,L,4'h3,8'h99, L,L,8'h1C,8'hA5};
    vecs[16] = '{L,L,4'h3,8'h99, L,L,4'h0,8'h00, H,L,L,L,4'h0,8'h00, H,L,8'h55,8'hA5};
    vecs[17] = '{L,L,4'h0,8'h00, L,L,4'h0,8'h00, L,L,L,L,4'h0,8'h00, L,L,8'h55,8'hA5};
    vecs[18] = '{L,L,4'h0,8'h00, L,L,4'h0,8'h00, L,L,L,L,4'h0,8'h00, L,L,8'h55,8'hA5};

`ifdef MEM_ARB_LOCK_EN
    expG0 = 8'b1011_1100;
    expG1 = 8'b0100_0010;
`else
    expG0 = 8'b0101_0100;
    expG1 = 8'b1010_1010;
`endif

    tbLoad   = 1'b1;
    clr      = 1'b0;
    m0_req   = 1'b1;
    m1_req   = 1'b1;
    m0_write = 1'b0;
    m1_write = 1'b0;
    m0_addr  = 4'h2;
    m1_addr  = 4'h5;
    m0_wdata = 8'h99;
    m1_wdata = 8'h66;
    m0_lock  = 1'b0;
    m1_lock  = 1'b0;

    stepCycle();
    tbLoad = 1'b0;
    stepCycle();
    checkOutput("reset m0_gnt", 8'(m0_gnt), 8'h00);
    checkOutput("reset m1_gnt", 8'(m1_gnt), 8'h00);
    checkOutput("reset mem_read", 8'(mem_read), 8'h00);
    checkOutput("reset mem_write", 8'(mem_write), 8'h00);
    checkOutput("reset mem_addr", 8'(mem_addr), 8'h00);
    checkOutput("reset m0_rvalid", 8'(m0_rvalid), 8'h00);
    checkOutput("reset m1_rvalid", 8'(m1_rvalid), 8'h00);
    clr = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
      stepCycle();
    end

    // Lock sequence: m0 locked, m1 requesting, starting from IDLE with last=0.
    m0_req  = 1'b1; m0_write = 1'b0; m0_addr = 4'h7; m0_lock = 1'b1;
    m1_req  = 1'b1; m1_write = 1'b0; m1_addr = 4'h5;
    for (int c = 0; c < 8; c++) begin
      #1;
      checkOutput($sformatf("lock cyc%0d m0_gnt", c), 8'(m0_gnt), 8'(expG0[c]));
      checkOutput($sformatf("lock cyc%0d m1_gnt", c), 8'(m1_gnt), 8'(expG1[c]));
      stepCycle();
    end
    m0_req  = 1'b0;
    m1_req  = 1'b0;
    m0_lock = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("post-lock idle m0_gnt", 8'(m0_gnt), 8'h00);
    checkOutput("post-lock idle m1_gnt", 8'(m1_gnt), 8'h00);

    // Reset asserted in the middle of an m0 write cycle must suppress the write.
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = 4'h2; m0_wdata = 8'hAA;
    stepCycle();
    #1;
    checkOutput("midwrite m0_gnt", 8'(m0_gnt), 8'h01);
    checkOutput("midwrite mem_write", 8'(mem_write), 8'h01);
    checkOutput("midwrite mem_wdata", mem_wdata, 8'hAA);
    clr = 1'b0;
    #1;
    checkOutput("midwrite-reset mem_write", 8'(mem_write), 8'h00);
    checkOutput("midwrite-reset m0_gnt", 8'(m0_gnt), 8'h00);
    checkOutput("midwrite-reset mem_addr", 8'(mem_addr), 8'h00);
    checkOutput("midwrite-reset mem_wdata", mem_wdata, 8'h00);
    checkOutput("midwrite-reset m0_rdata", m0_rdata, 8'h00);
    checkOutput("midwrite-reset m1_rdata", m1_rdata, 8'h00);
    stepCycle();
    checkOutput("midwrite memory[2]", tbMem[2], 8'h54);
    m0_req = 1'b0;
    clr    = 1'b1;
    stepCycle();
    checkOutput("after reset memory[2]", tbMem[2], 8'h54);
    checkOutput("after reset m0_gnt", 8'(m0_gnt), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single 16×8 unified instruction/data memory between the CPU (master 0) and a second requester such as a program loader or debug port (master 1). It sits between the masters and the memory array, serialises their accesses one per cycle with round-robin fairness, and returns registered read data with a valid pulse. The memory read is combinational; the memory write commits on the rising clock edge.

## Interface
- `ADDR_W`, default 4: memory address width.
- `DATA_W`, default 8: memory word width.
- `MAX_BURST`, default 4: maximum consecutive grants under lock (lock feature only; legal range 2..15).

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held until the matching grant is seen.
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read; sampled in the grant cycle.
- `m0_addr`, `m1_addr`  in  ADDR_W  access address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_lock`, `m1_lock`  in  1  request to keep the grant (lock feature only).
- `m0_gnt`, `m1_gnt`  out  1  registered grant; the access happens in this cycle.
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse when the matching `rdata` is updated.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  data to memory.
- `mem_rdata`  in  DATA_W  combinational data from memory.

## Operation
- FSM states: IDLE, G0, G1. `mX_gnt` = (state == GX). At most one grant is high.
- `last` register records the most recently granted master. Reset value is 1, so master 0 wins the first tie.
- Next state is evaluated every cycle in every state:
  - lock hold (feature only) takes priority: in GX with `mX_req` & `mX_lock` & `burst_cnt` < MAX_BURST-1 -> stay GX;
  - else both requests -> G(!last);
  - else a single request -> that master;
  - else IDLE.
- On entering or staying in GX: `last` <= X. `burst_cnt` increments when staying in GX and clears otherwise.
- Memory mux in GX with `mX_req`=1:
  - `mem_addr` = `mX_addr`, `mem_wdata` = `mX_wdata`;
  - `mem_write` = `mX_write`, `mem_read` = !`mX_write`.
- In IDLE, or in GX with `mX_req`=0: all `mem_*` outputs are 0 and no access occurs. The grant cycle is wasted and no `rvalid` follows.
- On a read in GX: `mX_rdata` <= `mem_rdata` and `mX_rvalid` <= 1 at the closing edge. Otherwise `rvalid` <= 0 and `rdata` holds its value.
- A master that keeps `req` high receives back-to-back grants only when the other master is idle. Otherwise grants alternate every cycle.

## Timing
- Reset (`clr`=0, asynchronous): state IDLE, `last`=1, `burst_cnt`=0. All `gnt`, `rvalid`, `rdata` and `mem_*` outputs are 0 immediately, without waiting for a clock edge.
- Reset mid-access: the strobes drop at once, so a write in progress is dropped and memory is unchanged.
- Request latency: `req` rises before edge N -> `gnt` is high for cycle N..N+1. A write commits at edge N+1; read data and `rvalid` appear in cycle N+1..N+2.
- Throughput: 1 access/cycle total.
- Simultaneous requests from IDLE after reset: master 0 is granted first, then master 1.
- `mX_write`/`addr`/`wdata` changes outside the grant cycle are ignored.

## Configuration
- `MEM_ARB_LOCK_EN` defined: the `mX_lock` inputs are honoured. A locked master holds the grant for up to MAX_BURST consecutive cycles. The grant is then forced to the other master if it is requesting; otherwise the burst counter restarts.
- `MEM_ARB_LOCK_EN` undefined: the `mX_lock` ports exist but are ignored, `burst_cnt` is not built, and arbitration is pure per-cycle round-robin.

## Test plan
- Reset: `clr`=0 with both `req`=1 -> all `gnt`/`rvalid`/`mem_*` = 0. After `clr`=1, first grant is to m0.
- Single read: memory[7]=0x1C, m0 reads addr 7 -> `m0_gnt` for 1 cycle, `mem_read`=1, `mem_addr`=7. Next cycle `m0_rdata`=0x1C and `m0_rvalid`=1 for exactly 1 cycle.
- Contention and write: m1 writes 0x55 to addr 3 while m0 continuously reads addr 3. Grants alternate m0,m1,m0,…; the m0 read after the m1 grant returns 0x55.
- Dropped request: m1 raises `req` 1 cycle, then drops it while granted -> `mem_*` = 0 in the grant cycle, no `m1_rvalid`, memory unchanged.
- Lock (with `MEM_ARB_LOCK_EN`, MAX_BURST=4): m0 `req`+`lock` held and m1 requesting -> m0 granted 4 consecutive cycles, then m1 for 1 cycle. Without the macro, grants alternate every cycle.
- Reset mid-write: `clr` falls during an m0 write of 0xAA to addr 2 (prior value 0x54) -> `mem_write` drops immediately and memory[2] stays 0x54.
